// File: rtl/multiplier_pkg.sv
// Shared types and helpers for the sequential Booth multiplier family.
// Holds FSM state encoding, radix-4 Booth digit flags and the iteration count helper.
package multiplier_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    DONE = ST_DONE
  } mult_state_e;

  // Booth digit as sign plus magnitude selects; all-zero flags encode digit 0.
  typedef struct packed {
    logic neg;
    logic x1;
    logic x2;
  } booth_digit_t;

  function automatic int booth_iters(input int width);
    return (width / 2) + 1;
  endfunction

endpackage

// File: rtl/booth_r4_encoder.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to {neg, x1, x2}.
// Purely combinational so it can be replicated in a parallel array.
module booth_r4_encoder
  import multiplier_pkg::*;
(
  input  logic [2:0]   win,
  output booth_digit_t dig
);

  // Window-to-digit table; 3'b111 and 3'b000 both yield digit 0 with neg cleared.
  always_comb begin
    dig = '{neg: 1'b0, x1: 1'b0, x2: 1'b0};
    case (win)
      3'b000: dig = '{neg: 1'b0, x1: 1'b0, x2: 1'b0};
      3'b001: dig = '{neg: 1'b0, x1: 1'b1, x2: 1'b0};
      3'b010: dig = '{neg: 1'b0, x1: 1'b1, x2: 1'b0};
      3'b011: dig = '{neg: 1'b0, x1: 1'b0, x2: 1'b1};
      3'b100: dig = '{neg: 1'b1, x1: 1'b0, x2: 1'b1};
      3'b101: dig = '{neg: 1'b1, x1: 1'b1, x2: 1'b0};
      3'b110: dig = '{neg: 1'b1, x1: 1'b1, x2: 1'b0};
      3'b111: dig = '{neg: 1'b0, x1: 1'b0, x2: 1'b0};
      default: dig = '{neg: 1'b0, x1: 1'b0, x2: 1'b0};
    endcase
  end

endmodule

// File: rtl/multiplier_signed_booth_seq.sv
// Sequential radix-4 Booth multiplier, signed or unsigned operands, two multiplier bits per cycle.
// Multiplicand is pre-shifted left each step so the accumulator only ever adds aligned partials.
module multiplier_signed_booth_seq
  import multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] q
);

  localparam int N     = booth_iters(WIDTH);
  localparam int CNT_W = $clog2(N + 1);
  localparam int EXT_W = WIDTH + 2;
  localparam int ACC_W = 2 * WIDTH + 4;

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("multiplier_signed_booth_seq: WIDTH must be even and >= 4");
  end

  mult_state_e        state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [ACC_W-1:0]   acc_r;
  logic [ACC_W-1:0]   mcand_r;
  logic [EXT_W-1:0]   mplr_r;
  logic               prev_r;
  logic [2*WIDTH-1:0] q_r;
  logic               out_valid_r;

  logic [EXT_W-1:0]   a_ext_s;
  logic [EXT_W-1:0]   b_ext_s;
  logic [2:0]         win_s;
  booth_digit_t       dig_s;
  logic [ACC_W-1:0]   pp_mag_s;
  logic [ACC_W-1:0]   pp_s;
  logic [ACC_W-1:0]   acc_next_s;
  logic               accept_s;
  logic               last_s;

  assign in_ready  = (state_r == IDLE);
  assign out_valid = out_valid_r;
  assign q         = q_r;

  assign accept_s = in_valid && (state_r == IDLE);
  assign last_s   = (cnt_r == CNT_W'(N - 1));
  assign win_s    = {mplr_r[1], mplr_r[0], prev_r};

  booth_r4_encoder u_enc (
    .win (win_s),
    .dig (dig_s)
  );

  // Operand extension into the signed Booth range.
  always_comb begin
    a_ext_s = {2'b00, a};
    b_ext_s = {2'b00, b};
    if (sgn) begin
      a_ext_s = {{2{a[WIDTH-1]}}, a};
      b_ext_s = {{2{b[WIDTH-1]}}, b};
    end else begin
      a_ext_s = {2'b00, a};
      b_ext_s = {2'b00, b};
    end
  end

  // Partial product select, conditional two's-complement negate, accumulate.
  always_comb begin
    pp_mag_s = {ACC_W{1'b0}};
    if (dig_s.x1) begin
      pp_mag_s = mcand_r;
    end else if (dig_s.x2) begin
      pp_mag_s = {mcand_r[ACC_W-2:0], 1'b0};
    end else begin
      pp_mag_s = {ACC_W{1'b0}};
    end
    if (dig_s.neg) begin
      pp_s = ~pp_mag_s + {{(ACC_W-1){1'b0}}, 1'b1};
    end else begin
      pp_s = pp_mag_s;
    end
    acc_next_s = acc_r + pp_s;
  end

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      mcand_r     <= {ACC_W{1'b0}};
      mplr_r      <= {EXT_W{1'b0}};
      prev_r      <= 1'b0;
      q_r         <= {(2*WIDTH){1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            mcand_r <= {{(ACC_W-EXT_W){a_ext_s[EXT_W-1]}}, a_ext_s};
            mplr_r  <= b_ext_s;
            prev_r  <= 1'b0;
            acc_r   <= {ACC_W{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            state_r <= CALC;
          end
        end
        CALC: begin
          acc_r   <= acc_next_s;
          mcand_r <= {mcand_r[ACC_W-3:0], 2'b00};
          mplr_r  <= {2'b00, mplr_r[EXT_W-1:2]};
          prev_r  <= mplr_r[1];
          cnt_r   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          if (last_s) begin
            q_r         <= acc_next_s[2*WIDTH-1:0];
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state_r     <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_signed_booth_seq.sv
// Directed-vector bench for multiplier_signed_booth_seq at WIDTH=8.
// Covers latency, signed/unsigned corners, backpressure, mid-operation reset and a seeded sweep.
module tb_multiplier_signed_booth_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rstn;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           sgn;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] q;

  int n_vec = 0;
  int n_err = 0;

  multiplier_signed_booth_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sgn       (sgn),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic s);
    int p;
    if (s) p = int'($signed(x)) * int'($signed(y));
    else   p = int'(x) * int'(y);
    return p[2*W-1:0];
  endfunction

  // Step edges until out_valid, bounded so a stuck DUT still reaches the summary.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 30) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] ai, input logic [W-1:0] bi,
                     input logic si, input logic [2*W-1:0] exp_q);
    int cyc;
    a = ai; b = bi; sgn = si; in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ai; b = ~bi; sgn = ~si;
    wait_done(cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'd5);
    chk({tag, "_q"}, 32'(q), 32'(exp_q));
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, "_ov_clr"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int cyc;
    int bad;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rs;

    rstn = 1'b0; in_valid = 1'b0; a = 8'h00; b = 8'h00; sgn = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_q", 32'(q), 32'd0);
    rstn = 1'b1;

    run("s_80x80", 8'h80, 8'h80, 1'b1, 16'h4000);
    run("u_FFxFF", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    run("s_FFxFF", 8'hFF, 8'hFF, 1'b1, 16'h0001);
    run("s_80x7F", 8'h80, 8'h7F, 1'b1, 16'hC080);
    run("s_FFx01", 8'hFF, 8'h01, 1'b1, 16'hFFFF);
    run("u_80x80", 8'h80, 8'h80, 1'b0, 16'h4000);
    run("u_7Fx03", 8'h7F, 8'h03, 1'b0, 16'h017D);
    run("s_05xFD", 8'h05, 8'hFD, 1'b1, 16'hFFF1);
    run("u_00xAB", 8'h00, 8'hAB, 1'b0, 16'h0000);
    run("s_7Fx7F", 8'h7F, 8'h7F, 1'b1, 16'h3F01);

    // Backpressure, with the next pair already offered while DONE.
    a = 8'h12; b = 8'h34; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(cyc);
    chk("bp_q", 32'(q), 32'h03A8);
    a = 8'h03; b = 8'h05; sgn = 1'b0; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (q !== 16'h03A8 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    chk("bp_stable", 32'(bad), 32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_idle_after_release", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_next_accepted", 32'(in_ready), 32'd0);
    wait_done(cyc);
    chk("bp_next_latency", 32'(cyc), 32'd5);
    chk("bp_next_q", 32'(q), 32'h000F);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Reset two digits into a computation.
    a = 8'h7F; b = 8'h7F; sgn = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_q", 32'(q), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rstn = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) bad++;
    end
    chk("mid_rst_no_stale", 32'(bad), 32'd0);

    // Seeded sweep against the arithmetic reference.
    for (int i = 0; i < 16; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rs = 1'($urandom);
      run($sformatf("rnd%0d", i), ra, rb, rs, ref_mul(ra, rb, rs));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
